// File: rtl/ulpi_reg_sched.sv
// ulpi_reg_sched
//   Schedules ULPI register operations. After reset it waits for the ULPI
//   engine to be ready, runs a two-entry init ROM, then serves two clients
//   (A and B) with round-robin arbitration. Failed operations are retried
//   with two idle cycles between attempts; a missing response is handled by
//   a saturating timeout counter.
//
// Ports
//   CLK_60M, NRST_A_USB        : ULPI clock, asynchronous active-low reset
//   READY, REG_DONE, REG_FAIL  : ULPI engine status / completion
//   REG_DATA_O                 : read data, valid with REG_DONE
//   REG_EN/RW/ADDR/DATA_I      : operation request to the ULPI engine
//   A_*/B_* inputs             : client requests (REQ held until ACK)
//   A_ACK/B_ACK, A_ERR/B_ERR   : one-cycle completion pulse with error flag
//   RDATA                      : read result, valid with either ACK
//   INIT_DONE, INIT_ERR        : sticky init status
module ulpi_reg_sched #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [7:0]  INIT_FC   = 8'h45
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic       READY,
    input  logic       REG_DONE,
    input  logic       REG_FAIL,
    input  logic [7:0] REG_DATA_O,
    output logic       REG_EN,
    output logic       REG_RW,
    output logic [5:0] REG_ADDR,
    output logic [7:0] REG_DATA_I,
    input  logic       A_REQ,
    input  logic       B_REQ,
    input  logic       A_RW,
    input  logic       B_RW,
    input  logic [5:0] A_ADDR,
    input  logic [5:0] B_ADDR,
    input  logic [7:0] A_WDATA,
    input  logic [7:0] B_WDATA,
    output logic       A_ACK,
    output logic       B_ACK,
    output logic       A_ERR,
    output logic       B_ERR,
    output logic [7:0] RDATA,
    output logic       INIT_DONE,
    output logic       INIT_ERR
);

    typedef enum logic [2:0] {
        BOOT, INIT_ISSUE, INIT_WAIT, ARB, ISSUE, WAIT, RESP
    } state_t;

    localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);
    localparam logic [7:0] TIMEOUT_L   = 8'(TIMEOUT);

    // Init ROM: OTG Control cleared first, then Function Control.
    localparam logic [5:0] ROM_ADDR [2] = '{6'h0A, 6'h04};
    localparam logic [7:0] ROM_DATA [2] = '{8'h00, INIT_FC};

    state_t     state_q, state_d;
    logic [1:0] boot_cnt_q, boot_cnt_d;
    logic       init_idx_q, init_idx_d;
    logic [2:0] retry_q, retry_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] idle_q, idle_d;
    logic       op_rw_q, op_rw_d;
    logic [5:0] op_addr_q, op_addr_d;
    logic [7:0] op_wdata_q, op_wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       last_b_q, last_b_d;   // last granted client; also the one being served
    logic       init_done_q, init_done_d;
    logic       init_err_q, init_err_d;

    logic op_ok, op_bad, retry_left, pick_b;

    // DONE has priority over FAIL and over an expiring timeout.
    assign op_ok      = REG_DONE;
    assign op_bad     = !REG_DONE && (REG_FAIL || (tmo_q >= TIMEOUT_L));
    assign retry_left = (retry_q < MAX_RETRY_L);
    // B wins only if A is idle or A was the last one granted.
    assign pick_b     = B_REQ && (!A_REQ || !last_b_q);

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            init_idx_q  <= 1'b0;
            retry_q     <= '0;
            tmo_q       <= '0;
            idle_q      <= '0;
            op_rw_q     <= 1'b0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            last_b_q    <= 1'b1;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            init_idx_q  <= init_idx_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            idle_q      <= idle_d;
            op_rw_q     <= op_rw_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            last_b_q    <= last_b_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        init_idx_d  = init_idx_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        idle_d      = idle_q;
        op_rw_d     = op_rw_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        last_b_d    = last_b_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        REG_EN      = 1'b0;

        case (state_q)
            BOOT: begin
                if (!READY) begin
                    boot_cnt_d = '0;
                end else if (boot_cnt_q == 2'd3) begin
                    // Fourth consecutive READY cycle: start the ROM.
                    boot_cnt_d = '0;
                    init_idx_d = 1'b0;
                    retry_d    = '0;
                    idle_d     = '0;
                    op_rw_d    = 1'b1;
                    op_addr_d  = ROM_ADDR[0];
                    op_wdata_d = ROM_DATA[0];
                    state_d    = INIT_ISSUE;
                end else begin
                    boot_cnt_d = boot_cnt_q + 2'd1;
                end
            end

            INIT_ISSUE, ISSUE: begin
                if (idle_q != 2'd0) begin
                    idle_d = idle_q - 2'd1;
                end else if (READY) begin
                    REG_EN  = 1'b1;
                    tmo_d   = '0;
                    state_d = (state_q == INIT_ISSUE) ? INIT_WAIT : WAIT;
                end
            end

            INIT_WAIT, WAIT: begin
                if (tmo_q < TIMEOUT_L) begin
                    tmo_d = tmo_q + 8'd1;
                end
                if (op_ok || (op_bad && !retry_left)) begin
                    if (state_q == INIT_WAIT) begin
                        if (!op_ok) begin
                            // Final failure skips the rest of the ROM.
                            init_err_d  = 1'b1;
                            init_done_d = 1'b1;
                            state_d     = ARB;
                        end else if (init_idx_q) begin
                            init_done_d = 1'b1;
                            state_d     = ARB;
                        end else begin
                            init_idx_d = 1'b1;
                            retry_d    = '0;
                            idle_d     = '0;
                            op_rw_d    = 1'b1;
                            op_addr_d  = ROM_ADDR[1];
                            op_wdata_d = ROM_DATA[1];
                            state_d    = INIT_ISSUE;
                        end
                    end else begin
                        err_d   = !op_ok;
                        rdata_d = (op_ok && !op_rw_q) ? REG_DATA_O : 8'h00;
                        state_d = RESP;
                    end
                end else if (op_bad) begin
                    retry_d = retry_q + 3'd1;
                    idle_d  = 2'd2;
                    state_d = (state_q == INIT_WAIT) ? INIT_ISSUE : ISSUE;
                end
            end

            ARB: begin
                if (init_done_q && READY && (A_REQ || B_REQ)) begin
                    last_b_d   = pick_b;
                    op_rw_d    = pick_b ? B_RW    : A_RW;
                    op_addr_d  = pick_b ? B_ADDR  : A_ADDR;
                    op_wdata_d = pick_b ? B_WDATA : A_WDATA;
                    retry_d    = '0;
                    idle_d     = '0;
                    state_d    = ISSUE;
                end
            end

            RESP: begin
                state_d = ARB;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign REG_RW     = op_rw_q;
    assign REG_ADDR   = op_addr_q;
    assign REG_DATA_I = op_wdata_q;
    assign A_ACK      = (state_q == RESP) && !last_b_q;
    assign B_ACK      = (state_q == RESP) && last_b_q;
    assign A_ERR      = A_ACK && err_q;
    assign B_ERR      = B_ACK && err_q;
    assign RDATA      = (state_q == RESP) ? rdata_q : 8'h00;
    assign INIT_DONE  = init_done_q;
    assign INIT_ERR   = init_err_q;

endmodule

// File: tb/tb_ulpi_reg_sched.sv
module tb_ulpi_reg_sched;

    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready = 1'b1;
    logic       reg_done = 1'b0;
    logic       reg_fail = 1'b0;
    logic [7:0] reg_data_o = 8'h00;
    logic       reg_en, reg_rw;
    logic [5:0] reg_addr;
    logic [7:0] reg_data_i;
    logic       a_req = 1'b0, b_req = 1'b0, a_rw = 1'b0, b_rw = 1'b0;
    logic [5:0] a_addr = 6'h00, b_addr = 6'h00;
    logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
    logic       a_ack, b_ack, a_err, b_err;
    logic [7:0] rdata;
    logic       init_done, init_err;

    ulpi_reg_sched #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .INIT_FC(8'h45)) dut (
        .CLK_60M(clk), .NRST_A_USB(rst_n), .READY(ready),
        .REG_DONE(reg_done), .REG_FAIL(reg_fail), .REG_DATA_O(reg_data_o),
        .REG_EN(reg_en), .REG_RW(reg_rw), .REG_ADDR(reg_addr), .REG_DATA_I(reg_data_i),
        .A_REQ(a_req), .B_REQ(b_req), .A_RW(a_rw), .B_RW(b_rw),
        .A_ADDR(a_addr), .B_ADDR(b_addr), .A_WDATA(a_wdata), .B_WDATA(b_wdata),
        .A_ACK(a_ack), .B_ACK(b_ack), .A_ERR(a_err), .B_ERR(b_err),
        .RDATA(rdata), .INIT_DONE(init_done), .INIT_ERR(init_err)
    );

    always #8 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic rw; logic [5:0] addr; logic [7:0] data; } op_t;
    typedef struct packed { logic b; logic err; logic [7:0] rdata; } ack_t;

    op_t  exp_ops[$], obs_ops[$];
    ack_t exp_acks[$], obs_acks[$];
    int   obs_en_cyc[$], obs_ack_cyc[$];

    // PHY model: 0=DONE, 1=FAIL, 2=silent, 3=DONE+FAIL; answers 3 cycles after REG_EN.
    int         mode = 0;
    int         rsp_cnt = 0;
    logic [7:0] phy_rdata = 8'h24;

    always @(negedge clk) begin
        reg_done   = 1'b0;
        reg_fail   = 1'b0;
        reg_data_o = 8'h00;
        if (!rst_n) begin
            rsp_cnt = 0;
        end else if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                case (mode)
                    0: begin reg_done = 1'b1; reg_data_o = phy_rdata; end
                    1: reg_fail = 1'b1;
                    3: begin reg_done = 1'b1; reg_fail = 1'b1; reg_data_o = phy_rdata; end
                    default: ;
                endcase
            end
        end
        if (reg_en) begin
            obs_ops.push_back(op_t'{reg_rw, reg_addr, reg_data_i});
            obs_en_cyc.push_back(cyc);
            if (rst_n && mode != 2) rsp_cnt = 3;
        end
        if (a_ack) begin
            obs_acks.push_back(ack_t'{1'b0, a_err, rdata});
            obs_ack_cyc.push_back(cyc);
        end
        if (b_ack) begin
            obs_acks.push_back(ack_t'{1'b1, b_err, rdata});
            obs_ack_cyc.push_back(cyc);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_init(input string tag, input int bound);
        int t = 0;
        while (!init_done && t < bound) begin
            tick(1);
            t++;
        end
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    task automatic wait_acks(input string tag, input int n, input int bound);
        int t = 0;
        while (obs_acks.size() < n && t < bound) begin
            tick(1);
            t++;
        end
        chk({tag, "_ack_seen"}, 32'(obs_acks.size() >= n), 32'd1);
    endtask

    task automatic check_ops(input string tag);
        op_t e, o;
        chk({tag, "_op_count"}, 32'(obs_ops.size()), 32'(exp_ops.size()));
        while (exp_ops.size() > 0 && obs_ops.size() > 0) begin
            e = exp_ops.pop_front();
            o = obs_ops.pop_front();
            chk({tag, "_op"}, 32'(o), 32'(e));
        end
        exp_ops.delete();
        obs_ops.delete();
        obs_en_cyc.delete();
    endtask

    task automatic check_acks(input string tag);
        ack_t e, o;
        chk({tag, "_ack_count"}, 32'(obs_acks.size()), 32'(exp_acks.size()));
        while (exp_acks.size() > 0 && obs_acks.size() > 0) begin
            e = exp_acks.pop_front();
            o = obs_acks.pop_front();
            chk({tag, "_ack"}, 32'(o), 32'(e));
        end
        exp_acks.delete();
        obs_acks.delete();
        obs_ack_cyc.delete();
    endtask

    initial begin
        int r, gap;

        // Reset values
        tick(3);
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_reg_bus", 32'({reg_rw, reg_addr, reg_data_i}), 32'd0);
        chk("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_init", 32'({init_done, init_err}), 32'd0);

        // Init with a silent PHY: entry 0 is tried 1+MAX_RETRY times, then init gives up
        mode = 2;
        repeat (MAX_RETRY + 1) exp_ops.push_back(op_t'{1'b1, 6'h0A, 8'h00});
        rst_n = 1'b1;
        wait_init("tmo", 1600);
        chk("tmo_init_err", 32'(init_err), 32'd1);
        tick(5);
        chk("tmo_en_count", 32'(obs_en_cyc.size()), 32'(MAX_RETRY + 1));
        for (int i = 1; i < obs_en_cyc.size(); i++) begin
            gap = obs_en_cyc[i] - obs_en_cyc[i-1];
            chk("tmo_retry_gap", 32'(gap >= TIMEOUT + 3 && gap <= TIMEOUT + 5), 32'd1);
        end
        check_ops("tmo");

        // Reset, then clean init with a READY glitch during BOOT
        rst_n = 1'b0;
        tick(2);
        chk("rst2_init_cleared", 32'({init_done, init_err}), 32'd0);
        mode = 0;
        obs_ops.delete();
        obs_en_cyc.delete();
        exp_ops.push_back(op_t'{1'b1, 6'h0A, 8'h00});
        exp_ops.push_back(op_t'{1'b1, 6'h04, 8'h45});
        rst_n = 1'b1;
        tick(3);
        ready = 1'b0;
        tick(1);
        ready = 1'b1;
        r = cyc;
        wait_init("init", 200);
        chk("init_err_clear", 32'(init_err), 32'd0);
        chk("boot_restart_latency", 32'(obs_en_cyc.size() > 0 ? obs_en_cyc[0] : -1), 32'(r + 4));
        tick(3);
        check_ops("init");

        // Round robin: both clients keep requesting; pointer starts at B so A goes first
        phy_rdata = 8'h24;
        a_rw = 1'b0; a_addr = 6'h11; a_wdata = 8'h00;
        b_rw = 1'b1; b_addr = 6'h22; b_wdata = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            exp_ops.push_back(op_t'{1'b0, 6'h11, 8'h00});
            exp_ops.push_back(op_t'{1'b1, 6'h22, 8'h5A});
            exp_acks.push_back(ack_t'{1'b0, 1'b0, 8'h24});
            exp_acks.push_back(ack_t'{1'b1, 1'b0, 8'h00});
        end
        a_req = 1'b1;
        b_req = 1'b1;
        wait_acks("rr", 4, 200);
        a_req = 1'b0;
        b_req = 1'b0;
        tick(10);
        check_acks("rr");
        check_ops("rr");

        // Single read, held off by READY=0, then latency checks
        a_rw = 1'b0; a_addr = 6'h00; a_wdata = 8'h00;
        ready = 1'b0;
        a_req = 1'b1;
        tick(6);
        chk("ready_low_no_en", 32'(obs_ops.size()), 32'd0);
        ready = 1'b1;
        r = cyc;
        exp_ops.push_back(op_t'{1'b0, 6'h00, 8'h00});
        exp_acks.push_back(ack_t'{1'b0, 1'b0, 8'h24});
        wait_acks("rd", 1, 50);
        a_req = 1'b0;
        tick(4);
        chk("rd_req_to_en", 32'(obs_en_cyc.size() > 0 ? obs_en_cyc[0] : -1), 32'(r + 1));
        chk("rd_en_to_ack", 32'(obs_ack_cyc.size() > 0 && obs_en_cyc.size() > 0 ?
                                obs_ack_cyc[0] - obs_en_cyc[0] : -1), 32'd4);
        check_acks("rd");
        check_ops("rd");

        // FAIL on every attempt: 1+MAX_RETRY pulses, then B_ACK with B_ERR
        mode = 1;
        b_rw = 1'b1; b_addr = 6'h33; b_wdata = 8'h77;
        repeat (MAX_RETRY + 1) exp_ops.push_back(op_t'{1'b1, 6'h33, 8'h77});
        exp_acks.push_back(ack_t'{1'b1, 1'b1, 8'h00});
        b_req = 1'b1;
        wait_acks("fail", 1, 200);
        b_req = 1'b0;
        tick(5);
        for (int i = 1; i < obs_en_cyc.size(); i++) begin
            gap = obs_en_cyc[i] - obs_en_cyc[i-1];
            chk("fail_retry_gap", 32'(gap >= 3), 32'd1);
        end
        check_acks("fail");
        check_ops("fail");

        // DONE and FAIL together: DONE wins
        mode = 3;
        phy_rdata = 8'h5C;
        a_rw = 1'b0; a_addr = 6'h3F; a_wdata = 8'h00;
        exp_ops.push_back(op_t'{1'b0, 6'h3F, 8'h00});
        exp_acks.push_back(ack_t'{1'b0, 1'b0, 8'h5C});
        a_req = 1'b1;
        wait_acks("both", 1, 50);
        a_req = 1'b0;
        tick(5);
        check_acks("both");
        check_ops("both");

        // Reset while waiting: no ACK, init reruns
        mode = 2;
        a_rw = 1'b0; a_addr = 6'h15;
        exp_ops.push_back(op_t'{1'b0, 6'h15, 8'h00});
        a_req = 1'b1;
        for (int t = 0; t < 20 && obs_ops.size() == 0; t++) tick(1);
        tick(3);
        rst_n = 1'b0;
        a_req = 1'b0;
        tick(2);
        chk("midrst_init_cleared", 32'({init_done, reg_en}), 32'd0);
        mode = 0;
        exp_ops.push_back(op_t'{1'b1, 6'h0A, 8'h00});
        exp_ops.push_back(op_t'{1'b1, 6'h04, 8'h45});
        rst_n = 1'b1;
        wait_init("midrst", 100);
        tick(5);
        check_acks("midrst");
        check_ops("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(16 * 60000);
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
